// File: rtl/sevenseg_pkg.sv
// Shared definitions for the multi-digit seven-segment scanner.
//   bcd_t         : one BCD digit (0..9 valid; 10..15 never produced)
//   SEG_0..SEG_9  : active-high a..g codes, bit 0 = a ... bit 6 = g
//   SEG_BLANK     : all segments off
//   scan_width()  : width of a scan index for n digits (at least 1 bit)
package sevenseg_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // A single-digit display still needs a 1-bit index so the scan register exists.
  function automatic int scan_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sevenseg_bcd_scan_if.sv
// Control and display bus of the seven-segment scanner.
//   en, clr, up : counter controls (driven by the controlling logic)
//   seg, dp     : shared segment bus a..g and decimal point
//   dig         : per-digit enables, one-hot when active
//   value       : current BCD count, digit i at [4i+3:4i]
//   tick, wrap  : one-cycle pulses on counter update / wrap-around
// modport master : the display driver (sevenseg_bcd_scan)
// modport slave  : the controlling logic / display consumer
interface sevenseg_bcd_scan_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    en;
  logic                    clr;
  logic                    up;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   dig;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    tick;
  logic                    wrap;

  modport master (
    input  en, clr, up,
    output seg, dp, dig, value, tick, wrap
  );

  modport slave (
    output en, clr, up,
    input  seg, dp, dig, value, tick, wrap
  );

endinterface

// File: rtl/sevenseg_decode.sv
// Combinational BCD to seven-segment decoder.
//   digit : BCD input
//   seg   : active-high segments a..g (bit 0 = a); codes 10..15 give blank
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] seg
);

  // Plain table lookup; anything outside 0..9 is shown dark.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_bcd_scan.sv
// Multi-digit seven-segment driver for the Vaman board: an N-digit BCD
// up/down counter advanced by a tick prescaler, and a time-multiplexed
// scanner driving a shared a..g/dp bus with per-digit enables.
//   clk  : board system clock (Sys_Clk0), rising edge
//   rst  : synchronous active-high reset, display dark
//   bus  : sevenseg_bcd_scan_if master (en/clr/up in; seg/dp/dig/value/tick/wrap out)
// Parameters: NUM_DIGITS (1..8), TICK_DIV (>=2), REFRESH_DIV (>=2),
//   SEG_ACTIVE_LOW, DIG_ACTIVE_LOW, LZ_BLANK.
module sevenseg_bcd_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 20000000,
  parameter int REFRESH_DIV    = 20000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int LZ_BLANK       = 1
) (
  input logic               clk,
  input logic               rst,
  sevenseg_bcd_scan_if.master bus
);

  localparam int SW = scan_width(NUM_DIGITS);
  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(REFRESH_DIV);

  localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST    = SW'(NUM_DIGITS - 1);

  // XOR masks turning active-high "lit/selected" into pin levels; the
  // masks themselves are the dark (inactive) levels.
  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ?
                                              {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]             presc;
  bcd_t [NUM_DIGITS-1:0]     value_q;
  bcd_t [NUM_DIGITS-1:0]     inc_val;
  bcd_t [NUM_DIGITS-1:0]     dec_val;
  logic                      inc_wrap;
  logic                      dec_wrap;
  logic                      tick_q;
  logic                      wrap_q;

  logic [RW-1:0]             refresh_cnt;
  logic [SW-1:0]             scan_idx;

  logic [NUM_DIGITS-1:0]     blank_mask;
  logic [NUM_DIGITS-1:0]     dig_sel;
  bcd_t                      cur_digit;
  logic                      cur_blank;
  logic [6:0]                dec_seg;

  logic [6:0]                seg_q;
  logic                      dp_q;
  logic [NUM_DIGITS-1:0]     dig_q;

  // Ripple carry/borrow through the digit chain. A carry (borrow) that
  // survives past the top digit means every digit was 9 (0): that is the wrap.
  always_comb begin
    inc_val  = value_q;
    dec_val  = value_q;
    inc_wrap = 1'b1;
    dec_wrap = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (inc_wrap) begin
        if (value_q[i] == 4'd9) begin
          inc_val[i] = 4'd0;
        end else begin
          inc_val[i] = value_q[i] + 4'd1;
          inc_wrap   = 1'b0;
        end
      end
      if (dec_wrap) begin
        if (value_q[i] == 4'd0) begin
          dec_val[i] = 4'd9;
        end else begin
          dec_val[i] = value_q[i] - 4'd1;
          dec_wrap   = 1'b0;
        end
      end
    end
  end

  // Prescaler and counter. clr beats a coincident tick; en only freezes the
  // prescaler so the tick phase resumes where it stopped.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      presc   <= '0;
      value_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (bus.en) begin
        if (presc == PRESC_LAST) begin
          presc   <= '0;
          tick_q  <= 1'b1;
          value_q <= bus.up ? inc_val : dec_val;
          wrap_q  <= bus.up ? inc_wrap : dec_wrap;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  // Free-running refresh divider stepping the scan index; ignores en and clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == SCAN_LAST) ? '0 : scan_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Leading-zero mask: digit i>0 is blank when it and all digits above are 0.
  // The scan mux then picks the selected digit, its blank flag and its enable.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above && (value_q[i] == 4'd0);
      blank_mask[i] = (LZ_BLANK != 0) && zero_above;
    end
    cur_digit = value_q[0];
    cur_blank = 1'b0;
    dig_sel   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == SW'(i)) begin
        cur_digit  = value_q[i];
        cur_blank  = blank_mask[i];
        dig_sel[i] = 1'b1;
      end
    end
  end

  sevenseg_decode u_decode (
    .digit (cur_digit),
    .seg   (dec_seg)
  );

  // Registered display bus; polarity applied last, after decode and blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= SEG_INV;
      dp_q  <= DP_INV;
      dig_q <= DIG_INV;
    end else begin
      seg_q <= (cur_blank ? SEG_BLANK : dec_seg) ^ SEG_INV;
      dp_q  <= (scan_idx == '0) ^ DP_INV;
      dig_q <= dig_sel ^ DIG_INV;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.dig   = dig_q;
  assign bus.value = value_q;
  assign bus.tick  = tick_q;
  assign bus.wrap  = wrap_q;

endmodule
